// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer slot scheduler between the camera-side frame writer and the
// HDMI-side frame reader: three DDR slots rotate so the reader never tears.
module frame_buffer_scheduler #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_STRIDE   = 32'h0004_0000,
    parameter int                        CNT_WIDTH      = 16
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      wr_frame_done,
    input  logic                      rd_frame_start,
    output logic [AXI_ADDR_WIDTH-1:0] wr_base_addr,
    output logic [AXI_ADDR_WIDTH-1:0] rd_base_addr,
    output logic [1:0]                wr_buf_idx,
    output logic [1:0]                rd_buf_idx,
    output logic                      rd_valid,
    output logic [CNT_WIDTH-1:0]      drop_cnt,
    output logic [CNT_WIDTH-1:0]      repeat_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR0 = BASE_ADDR;
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR1 = BASE_ADDR + FRAME_STRIDE;
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR2 = ADDR1 + FRAME_STRIDE;
    localparam logic [CNT_WIDTH-1:0]      CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t     state;
    logic [1:0] w, r, s;
    logic       fresh;
    logic       wr_done_d1;
    logic       rd_start_d1;

    logic       ev_w, ev_r;
    logic [1:0] w_n, r_n, s_n;
    logic       fresh_n;
    logic       drop_hit;
    logic       rep_hit;
    logic       rd_take;

    // Slot index to DDR base: three constants, index 3 never occurs.
    function automatic logic [AXI_ADDR_WIDTH-1:0] slot_addr(
        input logic [1:0] idx
    );
        case (idx)
            2'd1:    slot_addr = ADDR1;
            2'd2:    slot_addr = ADDR2;
            default: slot_addr = ADDR0;
        endcase
    endfunction

    assign ev_w = wr_frame_done & ~wr_done_d1;
    assign ev_r = rd_frame_start & ~rd_start_d1;

    // Write swap first, then the read swap sees the updated spare slot.
    always_comb begin
        w_n      = w;
        r_n      = r;
        s_n      = s;
        fresh_n  = fresh;
        drop_hit = 1'b0;
        rep_hit  = 1'b0;
        rd_take  = 1'b0;
        if (state != IDLE) begin
            if (ev_w) begin
                w_n      = s;
                s_n      = w;
                fresh_n  = 1'b1;
                drop_hit = fresh;
            end
            if (ev_r) begin
                if (fresh_n) begin
                    r_n     = s_n;
                    s_n     = r;
                    fresh_n = 1'b0;
                    rd_take = 1'b1;
                end else if (state == RUN) begin
                    rep_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            w            <= 2'd0;
            r            <= 2'd1;
            s            <= 2'd2;
            fresh        <= 1'b0;
            rd_valid     <= 1'b0;
            drop_cnt     <= '0;
            repeat_cnt   <= '0;
            wr_done_d1   <= 1'b0;
            rd_start_d1  <= 1'b0;
            wr_base_addr <= ADDR0;
            rd_base_addr <= ADDR1;
        end else begin
            wr_done_d1   <= wr_frame_done;
            rd_start_d1  <= rd_frame_start;
            wr_base_addr <= slot_addr(w);
            rd_base_addr <= slot_addr(r);
            if (!enable) begin
                state    <= IDLE;
                w        <= 2'd0;
                r        <= 2'd1;
                s        <= 2'd2;
                fresh    <= 1'b0;
                rd_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= PRIME;
                    end
                    PRIME, RUN: begin
                        w     <= w_n;
                        r     <= r_n;
                        s     <= s_n;
                        fresh <= fresh_n;
                        if (drop_hit && drop_cnt != CNT_MAX)
                            drop_cnt <= drop_cnt + 1'b1;
                        if (rep_hit && repeat_cnt != CNT_MAX)
                            repeat_cnt <= repeat_cnt + 1'b1;
                        if (rd_take) begin
                            state    <= RUN;
                            rd_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        rd_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wr_buf_idx = w;
    assign rd_buf_idx = r;

endmodule
